issue_dual_sched: RTL

- Dual-issue scheduler between decode and the Issue/EXE pipeline register.
- Buffers decoded PC_set entries in a circular queue and picks up to two in-order instructions per cycle.
- Presents the picks as out_set1 (slot A) and out_set2 (slot B); pairing hazards, load-use bubbles, DCache stall and branch flush are resolved here so the EXE register only sees legal pairs.

---
 rtl/issue_dual_sched_pkg.sv | 24 ++
 rtl/issue_dual_sched_if.sv | 18 +
 rtl/issue_dual_sched_pair_check.sv | 27 ++
 rtl/issue_dual_sched.sv | 86 ++++++++
 4 files changed

// File: rtl/issue_dual_sched_pkg.sv
// issue_dual_sched_pkg: shared PC_set entry type and memory-op helpers for the dual-issue scheduler.
package issue_dual_sched_pkg;
    localparam int LDST_MEM_BIT = 3;

    typedef struct packed {
        logic        o_valid;
        logic [15:0] pc;
        logic [4:0]  rf_raddr1;
        logic [4:0]  rf_raddr2;
        logic [4:0]  rf_rd;
        logic        rf_we;
        logic [3:0]  ldst_type;
        logic        mem_we;
        logic [2:0]  br_type;
    } PC_set;

    function automatic logic is_mem(PC_set s);
        return s.ldst_type[LDST_MEM_BIT];
    endfunction

    function automatic logic is_load(PC_set s);
        return is_mem(s) & ~s.mem_we;
    endfunction
endpackage

// File: rtl/issue_dual_sched_if.sv
// issue_dual_sched_if: decode-side inputs, issue-side outputs and control of the dual-issue scheduler.
interface issue_dual_sched_if #(parameter int DEPTH = 8);
    import issue_dual_sched_pkg::*;
    localparam int PTR_W = $clog2(DEPTH);
    PC_set            in_set1;
    PC_set            in_set2;
    PC_set            out_set1;
    PC_set            out_set2;
    logic             in_ready;
    logic             flush_BR;
    logic             stall_DCache;
    logic [PTR_W:0]   q_count;

    modport master (output in_set1, in_set2, flush_BR, stall_DCache,
                    input  in_ready, out_set1, out_set2, q_count);
    modport slave  (input  in_set1, in_set2, flush_BR, stall_DCache,
                    output in_ready, out_set1, out_set2, q_count);
endinterface

// File: rtl/issue_dual_sched_pair_check.sv
// issue_pair_check: load-use hazards for slots A/B and legality of issuing B alongside A.
module issue_pair_check
    import issue_dual_sched_pkg::*;
(
    input  PC_set      a,
    input  PC_set      b,
    input  logic       ld_v,
    input  logic [4:0] ld_rd,
    output logic       lu_a,
    output logic       lu_b,
    output logic       pair_ok
);
    logic raw, waw, unused_fields;

    function automatic logic lu(PC_set x, logic v, logic [4:0] rd);
        return v & (rd != 5'd0) & ((x.rf_raddr1 == rd) | (x.rf_raddr2 == rd));
    endfunction

    assign lu_a    = lu(a, ld_v, ld_rd);
    assign lu_b    = lu(b, ld_v, ld_rd);
    assign raw     = a.rf_we & (a.rf_rd != 5'd0) & ((a.rf_rd == b.rf_raddr1) | (a.rf_rd == b.rf_raddr2));
    assign waw     = a.rf_we & b.rf_we & (a.rf_rd == b.rf_rd) & (a.rf_rd != 5'd0);
    // single DCache port, and nothing may ride behind a branch
    assign pair_ok = ~raw & ~waw & ~(is_mem(a) & is_mem(b)) & (a.br_type == 3'd0);
    assign unused_fields = ^{a.o_valid, a.pc, a.mem_we, a.ldst_type[2:0],
                             b.o_valid, b.pc, b.mem_we, b.ldst_type[2:0], b.br_type};
endmodule

// File: rtl/issue_dual_sched.sv
// issue_dual_sched: circular issue queue picking up to two in-order instructions per cycle.
module issue_dual_sched
    import issue_dual_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input logic                clk,
    input logic                rstn,
    issue_dual_sched_if.slave  io
);
    localparam int PTR_W = $clog2(DEPTH);

    PC_set            mem_q [DEPTH];
    PC_set            mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head_n1;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             ld_v_q, ld_v_d;
    logic [4:0]       ld_rd_q, ld_rd_d;
    PC_set            ent_a, ent_b;
    logic             lu_a, lu_b, pair_ok, issue_a, issue_b, do_enq, v1, v2, ld_b, ld_a;
    logic [1:0]       enq_n, deq_n;

    issue_pair_check u_chk (
        .a       (ent_a),
        .b       (ent_b),
        .ld_v    (ld_v_q),
        .ld_rd   (ld_rd_q),
        .lu_a    (lu_a),
        .lu_b    (lu_b),
        .pair_ok (pair_ok)
    );

    always_comb begin
        head_n1      = head_q + PTR_W'(1);
        ent_a        = mem_q[head_q];
        ent_b        = mem_q[head_n1];
        io.in_ready  = cnt_q <= (PTR_W+1)'(DEPTH - 2);
        issue_a      = (cnt_q != 0) & ~io.flush_BR & ~io.stall_DCache & ~lu_a;
        issue_b      = issue_a & (cnt_q >= 2) & ~lu_b & pair_ok;
        io.out_set1  = ent_a;
        io.out_set1.o_valid = issue_a;
        io.out_set2  = ent_b;
        io.out_set2.o_valid = issue_b;
        io.q_count   = cnt_q;
        v1           = io.in_set1.o_valid;
        v2           = io.in_set2.o_valid;
        do_enq       = io.in_ready & ~io.flush_BR;
        enq_n        = do_enq ? {1'b0, v1} + {1'b0, v2} : 2'd0;
        deq_n        = {1'b0, issue_a} + {1'b0, issue_b};
        mem_d        = mem_q;
        // a lone in_set2 lands at tail so the queue stays compacted
        if (do_enq & v1) mem_d[tail_q] = io.in_set1;
        if (do_enq & v2) mem_d[tail_q + PTR_W'(v1)] = io.in_set2;
        tail_d       = tail_q + PTR_W'(enq_n);
        head_d       = head_q + PTR_W'(deq_n);
        cnt_d        = cnt_q + (PTR_W+1)'(enq_n) - (PTR_W+1)'(deq_n);
        ld_b         = issue_b & is_load(ent_b);
        ld_a         = issue_a & is_load(ent_a);
        ld_v_d       = io.stall_DCache ? ld_v_q : ld_b | ld_a;
        ld_rd_d      = io.stall_DCache ? ld_rd_q : ld_b ? ent_b.rf_rd : ld_a ? ent_a.rf_rd : ld_rd_q;
        if (io.flush_BR) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
            ld_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            ld_v_q  <= 1'b0;
            ld_rd_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            ld_v_q  <= ld_v_d;
            ld_rd_q <= ld_rd_d;
        end
    end
endmodule
